bwd_pipe: RTL and testbench

BWD_PIPE -- requirements
Module: bwd_pipe

---
 rtl/bwd_pipe.sv | 121 ++++++++++++
 tb/tb_bwd_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bwd_pipe.sv
// bwd_pipe: single-entry skid buffer that registers the backward (ready)
// path while keeping a zero-latency forward path when the skid is empty.
// A saturating counter records how many cycles a valid beat was held off
// by the downstream side.
module bwd_pipe #(
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid_in,
    input  logic [DATA_W-1:0] f_data_in,
    output logic              f_ready_out,
    output logic              b_valid_out,
    output logic [DATA_W-1:0] b_data_out,
    input  logic              b_ready_in,
    input  logic              flush,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              occ
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ready;
    logic                w_capture;
    logic [DATA_W-1:0]   r_skid;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    w_cnt_max;
    logic                w_stall;

    assign w_cnt_max   = {CNT_W{1'b1}};
    assign f_ready_out = r_ready;
    assign occ         = (r_state == ST_FULL);
    assign stall_cnt   = r_stall_cnt;
    assign w_stall     = b_valid_out & ~b_ready_in;

    // Next-state, capture strobe and forward outputs; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        b_valid_out = 1'b0;
        b_data_out  = f_data_in;
        case (r_state)
            ST_EMPTY: begin
                b_data_out = f_data_in;
                if (flush) begin
                    b_valid_out = 1'b0;
                    w_state_nxt = ST_EMPTY;
                end else begin
                    b_valid_out = f_valid_in;
                    if (f_valid_in && !b_ready_in) begin
                        w_state_nxt = ST_FULL;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            ST_FULL: begin
                b_data_out = r_skid;
                if (flush) begin
                    b_valid_out = 1'b0;
                    w_state_nxt = ST_EMPTY;
                end else begin
                    b_valid_out = 1'b1;
                    if (b_ready_in) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            default: begin
                b_valid_out = 1'b0;
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register plus a dedicated ready flop so f_ready_out never sees b_ready_in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_EMPTY);
        end
    end

    // Skid data only loads on the EMPTY->FULL capture edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_skid <= {DATA_W{1'b0}};
        end else if (w_capture) begin
            r_skid <= f_data_in;
        end else begin
            r_skid <= r_skid;
        end
    end

    // Saturating backpressure counter; clear wins over increment, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (stall_clr) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != w_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_bwd_pipe.sv
// Testbench for bwd_pipe: directed scenarios followed by random stress,
// compared against a FIFO-style reference of accepted/delivered beats.
module tb_bwd_pipe;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          f_valid_in;
    logic [DW-1:0] f_data_in;
    logic          f_ready_out;
    logic          b_valid_out;
    logic [DW-1:0] b_data_out;
    logic          b_ready_in;
    logic          flush;
    logic          stall_clr;
    logic [CW-1:0] stall_cnt;
    logic          occ;

    int n_vec;
    int n_err;

    // Reference state: beats accepted upstream but not yet delivered, and the stall count.
    logic [DW-1:0] q[$];
    int            m_cnt;

    bwd_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_valid_in (f_valid_in),
        .f_data_in  (f_data_in),
        .f_ready_out(f_ready_out),
        .b_valid_out(b_valid_out),
        .b_data_out (b_data_out),
        .b_ready_in (b_ready_in),
        .flush      (flush),
        .stall_clr  (stall_clr),
        .stall_cnt  (stall_cnt),
        .occ        (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive, check against the reference, clock, update reference.
    task automatic step(input logic fv, input logic [DW-1:0] fd, input logic br,
                        input logic fl, input logic sc, input logic rn);
        logic          e_rdy;
        logic          e_bv;
        logic [DW-1:0] e_bd;
        f_valid_in = fv;
        f_data_in  = fd;
        b_ready_in = br;
        flush      = fl;
        stall_clr  = sc;
        rst_n      = rn;
        #2;
        e_rdy = (q.size() == 0);
        e_bv  = fl ? 1'b0 : ((q.size() != 0) ? 1'b1 : fv);
        e_bd  = (q.size() != 0) ? q[0] : fd;
        chk("f_ready_out", {31'd0, f_ready_out}, {31'd0, e_rdy});
        chk("occ", {31'd0, occ}, {31'd0, ~e_rdy});
        chk("b_valid_out", {31'd0, b_valid_out}, {31'd0, e_bv});
        if (e_bv) begin
            chk("b_data_out", {24'd0, b_data_out}, {24'd0, e_bd});
        end
        chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
        // Toggle downstream ready: upstream ready must not follow it.
        b_ready_in = ~br;
        #1;
        chk("ready_comb", {31'd0, f_ready_out}, {31'd0, e_rdy});
        b_ready_in = br;
        #1;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (sc) m_cnt = 0;
            else if (e_bv && !br && m_cnt < 15) m_cnt = m_cnt + 1;
            if (fl) begin
                q.delete();
            end else begin
                if (fv && e_rdy) q.push_back(fd);
                if (e_bv && br) void'(q.pop_front());
            end
        end
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_cnt      = 0;
        rst_n      = 1'b0;
        f_valid_in = 1'b0;
        f_data_in  = 8'h00;
        b_ready_in = 1'b0;
        flush      = 1'b0;
        stall_clr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        q.delete();

        // Reset state and pass-through of 0x11, 0x22, 0x33.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pass_stall_zero", {28'd0, stall_cnt}, 32'd0);

        // Skid capture of 0xA5 then release.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("skid_occ", {31'd0, occ}, 32'd1);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("skid_ready_back", {31'd0, f_ready_out}, 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Saturation: hold FULL for 20 cycles.
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_15", {28'd0, stall_cnt}, 32'd15);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_zero", {28'd0, stall_cnt}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush of a held 0x5A.
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_occ", {31'd0, occ}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);

        // Sync reset while FULL.
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_occ", {31'd0, occ}, 32'd0);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

        // Random stress.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 499) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
